// File: rtl/axis_packet_arbiter_pkg.sv
// Shared definitions for axis_packet_arbiter.
//   - AXI-Stream beat widths (512-bit data, 64-bit keep, 1-bit user)
//   - arbiter state enum and packed beat struct
//   - rr_pick(): round-robin search helper
package axis_packet_arbiter_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 512;
    localparam int unsigned AXIS_KEEP_WIDTH = 64;
    localparam int unsigned AXIS_USER_WIDTH = 1;
    localparam int unsigned MAX_PORTS       = 16;
    localparam int unsigned PORT_IDX_W      = 4;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic [AXIS_KEEP_WIDTH-1:0] tkeep;
        logic                       tlast;
        logic [AXIS_USER_WIDTH-1:0] tuser;
    } axis_beat_t;

    // First requesting port after last_idx, wrapping at num. Bounds are constant so the loop
    // unrolls; num is a parameter at every call site.
    function automatic int unsigned rr_pick(input logic [MAX_PORTS-1:0] req,
                                            input int unsigned last_idx,
                                            input int unsigned num);
        int unsigned idx;
        logic        found;
        found   = 1'b0;
        rr_pick = 0;
        for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
            if (k <= num) begin
                idx = last_idx + k;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (!found && req[idx[PORT_IDX_W-1:0]]) begin
                    found   = 1'b1;
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/axi_stream.sv
// AXI-Stream bundle: valid/ready handshake, 512-bit data, 64-bit keep, last, 1-bit user.
//   master modport drives payload and valid, slave modport drives ready.
interface axi_stream;
    import axis_packet_arbiter_pkg::*;

    logic                       tvalid;
    logic                       tready;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic [AXIS_KEEP_WIDTH-1:0] tkeep;
    logic                       tlast;
    logic [AXIS_USER_WIDTH-1:0] tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/axis_arb_out_reg.sv
// Output pipeline stage: one main register plus one skid entry.
// Ports:
//   aclk, areset        - clock, synchronous active-high reset (empties both entries)
//   s_valid_i/s_ready_o - upstream handshake, s_beat_i payload
//   m_valid_o/m_ready_i - downstream handshake, m_beat_o payload
// s_ready_o depends only on registered state, so upstream never sees a combinational path from
// m_ready_i.
module axis_arb_out_reg
    import axis_packet_arbiter_pkg::*;
(
    input  logic       aclk,
    input  logic       areset,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  axis_beat_t s_beat_i,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output axis_beat_t m_beat_o
);

    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    axis_beat_t main_q, main_d;
    axis_beat_t skid_q, skid_d;
    logic       accept;

    assign s_ready_o = !skid_valid_q;
    assign accept    = s_valid_i && s_ready_o;
    assign m_valid_o = main_valid_q;
    assign m_beat_o  = main_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!main_valid_q || m_ready_i) begin
            // Main slot frees up: refill from skid first to keep order.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = s_beat_i;
                end
            end
        end else if (accept) begin
            // Downstream stalled while a beat was already in flight.
            skid_valid_d = 1'b1;
            skid_d       = s_beat_i;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter for NUM_PORTS AXI-Stream inputs onto one output.
// Ports:
//   aclk, areset        - clock, synchronous active-high reset
//   s_axis[NUM_PORTS]   - requester streams (slave side)
//   m_axis              - arbitrated stream through a skid output register
//   grant               - index of the locked port, held while idle
//   busy                - high while a packet is locked
//   pkt_cnt[NUM_PORTS]  - per-port completed-packet counters (only with AXIS_ARB_PKT_CNT_EN)
// Build option: define AXIS_ARB_PKT_CNT_EN to add the pkt_cnt port and counters.
module axis_packet_arbiter
    import axis_packet_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    axi_stream.slave                     s_axis [NUM_PORTS],
    axi_stream.master                    m_axis,
    output logic [$clog2(NUM_PORTS)-1:0] grant,
    output logic                         busy
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]         pkt_cnt [NUM_PORTS]
`endif
);

    localparam int unsigned GrantW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] s_valid;
    logic [NUM_PORTS-1:0] s_ready;
    axis_beat_t           s_beat [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unroll
        assign s_valid[i]       = s_axis[i].tvalid;
        assign s_beat[i]        = {s_axis[i].tdata, s_axis[i].tkeep, s_axis[i].tlast,
                                   s_axis[i].tuser};
        assign s_axis[i].tready = s_ready[i];
    end

    arb_state_e          state_q, state_d;
    logic [GrantW-1:0]   grant_q, grant_d;
    logic [GrantW-1:0]   last_grant_q, last_grant_d;
    logic [MAX_PORTS-1:0] req_pad;
    logic                out_valid, out_ready, pkt_done;
    axis_beat_t          out_beat;
    logic                m_valid;
    axis_beat_t          m_beat;

    always_comb begin
        req_pad                 = '0;
        req_pad[NUM_PORTS-1:0]  = s_valid;
        state_d                 = state_q;
        grant_d                 = grant_q;
        last_grant_d            = last_grant_q;
        s_ready                 = '0;
        out_valid               = 1'b0;
        out_beat                = s_beat[grant_q];
        pkt_done                = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|s_valid) begin
                    grant_d = GrantW'(rr_pick(req_pad, 32'(last_grant_q), NUM_PORTS));
                    state_d = StLocked;
                end
            end
            StLocked: begin
                // Ready and valid both masked during reset so nothing is accepted upstream.
                out_valid         = s_valid[grant_q] && !areset;
                s_ready[grant_q]  = out_ready && !areset;
                pkt_done          = out_valid && out_ready && out_beat.tlast;
                if (pkt_done) begin
                    state_d      = StIdle;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GrantW'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    axis_arb_out_reg u_out_reg (
        .aclk      (aclk),
        .areset    (areset),
        .s_valid_i (out_valid),
        .s_ready_o (out_ready),
        .s_beat_i  (out_beat),
        .m_valid_o (m_valid),
        .m_ready_i (m_axis.tready),
        .m_beat_o  (m_beat)
    );

    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_beat.tdata;
    assign m_axis.tkeep  = m_beat.tkeep;
    assign m_axis.tlast  = m_beat.tlast;
    assign m_axis.tuser  = m_beat.tuser;
    assign grant         = grant_q;
    assign busy          = (state_q == StLocked);

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pkt_done && (grant_q == GrantW'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (areset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-port source memories feed the DUT, a monitor
// captures output beats and grant events, and results are compared to hand-built expectations.
module tb_axis_packet_arbiter;
    import axis_packet_arbiter_pkg::*;

    localparam int unsigned NP    = 4;
    localparam int unsigned CW    = 32;
    localparam int unsigned Depth = 32;

    logic aclk = 1'b0;
    logic areset;
    logic m_ready;
    logic [1:0] grant;
    logic busy;
`ifdef AXIS_ARB_PKT_CNT_EN
    logic [CW-1:0] pkt_cnt [NP];
`endif

    always #5 aclk = ~aclk;

    axi_stream s_if [NP] ();
    axi_stream m_if ();

    logic       s_valid [NP];
    logic       s_ready [NP];
    logic       hold    [NP];
    axis_beat_t s_beat  [NP];

    for (genvar i = 0; i < NP; i++) begin : g_if
        assign s_if[i].tvalid = s_valid[i];
        assign s_if[i].tdata  = s_beat[i].tdata;
        assign s_if[i].tkeep  = s_beat[i].tkeep;
        assign s_if[i].tlast  = s_beat[i].tlast;
        assign s_if[i].tuser  = s_beat[i].tuser;
        assign s_ready[i]     = s_if[i].tready;
    end
    assign m_if.tready = m_ready;

    axis_packet_arbiter #(
        .NUM_PORTS (NP),
        .CNT_WIDTH (CW)
    ) u_dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_axis  (s_if),
        .m_axis  (m_if),
        .grant   (grant),
        .busy    (busy)
`ifdef AXIS_ARB_PKT_CNT_EN
        ,
        .pkt_cnt (pkt_cnt)
`endif
    );

    axis_beat_t src_mem [NP][Depth];
    int         src_wr  [NP];
    int         src_rd  [NP];
    axis_beat_t out_mem [64];
    int         out_cyc [64];
    int         in_cyc  [64];
    int         grant_log [16];
    int         out_n, in_n, grant_n;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check_value(input string tag, input logic [577:0] got,
                               input logic [577:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic axis_beat_t make_beat(input int port, input int pkt, input int idx,
                                             input bit last);
        axis_beat_t  b;
        logic [31:0] w;
        w       = {8'(port), 8'(pkt), 8'(idx), 8'h5a};
        b.tdata = {16{w}};
        b.tkeep = {w, ~w};
        b.tlast = last;
        b.tuser = 1'(idx ^ port);
        return b;
    endfunction

    task automatic load_pkt(input int port, input int pkt, input int len);
        for (int k = 0; k < len; k++) begin
            src_mem[port][src_wr[port]] = make_beat(port, pkt, k, k == len - 1);
            src_wr[port]++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic do_reset;
        areset  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < NP; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
            hold[i]   = 1'b0;
        end
        step(2);
        out_n   = 0;
        in_n    = 0;
        grant_n = 0;
        areset  = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (out_n < n && c < budget) begin
            step(1);
            c++;
        end
        check_value(tag, 578'(out_n), 578'(n));
    endtask

    // Cycle counter
    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    // Source driver: handshake sampled at negedge, next beat presented 1 time unit after posedge.
    initial begin
        bit fire [NP];
        for (int i = 0; i < NP; i++) begin
            s_valid[i] = 1'b0;
            s_beat[i]  = '0;
        end
        forever begin
            @(negedge aclk);
            for (int i = 0; i < NP; i++) begin
                fire[i] = s_valid[i] && s_ready[i];
                if (fire[i] && in_n < 64) begin
                    in_cyc[in_n] = cyc;
                    in_n++;
                end
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (fire[i]) src_rd[i]++;
                s_valid[i] = (src_rd[i] < src_wr[i]) && !hold[i];
                if (src_rd[i] < src_wr[i]) s_beat[i] = src_mem[i][src_rd[i]];
            end
        end
    end

    // Output and grant monitor
    initial begin
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge aclk);
            if (m_if.tvalid && m_ready && out_n < 64) begin
                out_mem[out_n] = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
                out_cyc[out_n] = cyc;
                out_n++;
            end
            if (busy && !busy_prev && grant_n < 16) begin
                grant_log[grant_n] = int'(grant);
                grant_n++;
            end
            busy_prev = busy;
        end
    end

    initial begin
        int c;
        int exp_g [6];
        exp_g = '{0, 1, 2, 3, 0, 1};
        out_n   = 0;
        in_n    = 0;
        grant_n = 0;

        // Reset state
        do_reset;
        areset = 1'b1;
        step(1);
        check_value("rst_ready0", 578'(s_ready[0]), 578'(0));
        areset = 1'b0;
        step(1);
        check_value("rst_busy", 578'(busy), 578'(0));
        check_value("rst_grant", 578'(grant), 578'(0));
        check_value("rst_mvalid", 578'(m_if.tvalid), 578'(0));

        // Ports 0 and 2 with 3-beat packets: port 0 first, one arbitration gap
        do_reset;
        load_pkt(0, 0, 3);
        load_pkt(2, 0, 3);
        wait_out(6, 40, "t1_count");
        for (int k = 0; k < 3; k++) begin
            check_value("t1_p0_beat", out_mem[k], make_beat(0, 0, k, k == 2));
            check_value("t1_p2_beat", out_mem[k + 3], make_beat(2, 0, k, k == 2));
        end
        check_value("t1_b2b", 578'(out_cyc[1] - out_cyc[0]), 578'(1));
        check_value("t1_gap", 578'(out_cyc[3] - out_cyc[2]), 578'(2));

        // All ports valid with single-beat packets: rotating grants
        do_reset;
        for (int p = 0; p < NP; p++) begin
            load_pkt(p, 0, 1);
            load_pkt(p, 1, 1);
        end
        wait_out(8, 60, "t2_count");
        for (int k = 0; k < 6; k++) begin
            check_value("t2_grant", 578'(grant_log[k]), 578'(exp_g[k]));
            check_value("t2_beat", out_mem[k], make_beat(k % 4, k / 4, 0, 1'b1));
        end
        check_value("t2_lat0", 578'(out_cyc[0] - in_cyc[0]), 578'(1));
        check_value("t2_lat4", 578'(out_cyc[4] - in_cyc[4]), 578'(1));

        // 8-beat packet with m_ready toggling 1,0,1,0
        do_reset;
        load_pkt(1, 0, 8);
        c = 0;
        while (out_n < 8 && c < 60) begin
            m_ready = (c % 2 == 0);
            step(1);
            c++;
        end
        m_ready = 1'b1;
        check_value("t3_count", 578'(out_n), 578'(8));
        for (int k = 0; k < 8; k++) begin
            check_value("t3_beat", out_mem[k], make_beat(1, 0, k, k == 7));
        end

        // Port 3 stalls mid-packet while port 0 waits
        do_reset;
        load_pkt(3, 0, 4);
        c = 0;
        while (src_rd[3] < 1 && c < 20) begin
            step(1);
            c++;
        end
        check_value("t4_started", 578'(src_rd[3] >= 1), 578'(1));
        hold[3] = 1'b1;
        load_pkt(0, 0, 2);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check_value("t4_grant", 578'(grant), 578'(3));
            check_value("t4_p0_ready", 578'(s_ready[0]), 578'(0));
        end
        hold[3] = 1'b0;
        wait_out(6, 40, "t4_count");
        for (int k = 0; k < 4; k++) begin
            check_value("t4_p3_beat", out_mem[k], make_beat(3, 0, k, k == 3));
        end
        check_value("t4_p0_beat", out_mem[4], make_beat(0, 0, 0, 1'b0));

        // Reset on beat 2 of a 4-beat packet from port 2
        do_reset;
        m_ready = 1'b0;
        load_pkt(2, 0, 4);
        c = 0;
        while (src_rd[2] < 2 && c < 20) begin
            step(1);
            c++;
        end
        check_value("t5_beats_in", 578'(src_rd[2]), 578'(2));
        areset = 1'b1;
        load_pkt(0, 0, 1);
        step(1);
        check_value("t5_mvalid", 578'(m_if.tvalid), 578'(0));
        check_value("t5_busy", 578'(busy), 578'(0));
        check_value("t5_ready2", 578'(s_ready[2]), 578'(0));
        areset  = 1'b0;
        m_ready = 1'b1;
        c = 0;
        while (!busy && c < 10) begin
            step(1);
            c++;
        end
        check_value("t5_grant", 578'(grant), 578'(0));
        wait_out(1, 10, "t5_count");
        check_value("t5_beat", out_mem[0], make_beat(0, 0, 0, 1'b1));

`ifdef AXIS_ARB_PKT_CNT_EN
        // Packet counters: 5 on port 1, 2 on port 2
        do_reset;
        for (int k = 0; k < 5; k++) load_pkt(1, k, 2);
        for (int k = 0; k < 2; k++) load_pkt(2, k, 1);
        wait_out(12, 100, "t6_count");
        step(2);
        check_value("t6_cnt0", 578'(pkt_cnt[0]), 578'(0));
        check_value("t6_cnt1", 578'(pkt_cnt[1]), 578'(CW'(5)));
        check_value("t6_cnt2", 578'(pkt_cnt[2]), 578'(CW'(2)));
        check_value("t6_cnt3", 578'(pkt_cnt[3]), 578'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of slave stream inputs (legal 2..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each packet counter.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port aclk, input, 1, the sole clock; all logic is rising-edge.
REQ-005 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port s_axis[NUM_PORTS], axi_stream.slave, 512 data / 64 keep / last / user, requester inputs.
REQ-007 SHALL have port m_axis, axi_stream.master, 512 data / 64 keep / last / user, arbitrated output.
REQ-008 SHALL have port grant, output, $clog2(NUM_PORTS), index of the currently locked port.
REQ-009 SHALL have port busy, output, 1, high while a packet is locked.

Function
REQ-010 SHALL arbitrate at packet granularity; once granted, a port keeps the output until its beat with last=1 transfers.
REQ-011 SHALL use states IDLE and LOCKED.
REQ-012 In IDLE with one or more s_axis valid, SHALL grant the first valid port searching round-robin from last_grant+1 mod NUM_PORTS, and enter LOCKED next cycle.
REQ-013 In IDLE with no valid input, SHALL remain in IDLE.
REQ-014 In LOCKED, SHALL set s_axis[grant].ready = output-stage ready and hold every other s_axis ready at 0.
REQ-015 In IDLE, SHALL hold all s_axis ready at 0.
REQ-016 When the granted port's last beat is accepted, SHALL update last_grant := grant and return to IDLE, leaving exactly one arbitration cycle between packets.
REQ-017 SHALL pass data, keep, last and user unmodified through a one-entry-plus-skid output register: 1-cycle latency from input acceptance to m_axis.valid, full throughput of 1 beat/cycle under continuous m_axis.ready.
REQ-018 SHALL never drop, duplicate or reorder beats when m_axis.ready deasserts, including on the cycle of the last beat.
REQ-019 SHALL not interleave beats of different packets on m_axis.
REQ-020 A single-beat packet (valid and last on the first beat) SHALL lock for exactly one accepted beat.
REQ-021 If a granted port drops valid mid-packet, SHALL stay LOCKED on that port (no timeout).
REQ-022 busy SHALL be 1 exactly in LOCKED; grant SHALL hold its value in IDLE.

Reset
REQ-023 On areset=1 at a clock edge, SHALL enter IDLE, set last_grant = NUM_PORTS-1 (port 0 first priority), grant = 0, busy = 0, m_axis.valid = 0, and empty the output register.
REQ-024 Reset mid-packet SHALL discard buffered beats; the upstream remainder is not recovered.
REQ-025 SHALL hold all s_axis ready at 0 while areset=1.

Configuration
REQ-026 With macro AXIS_ARB_PKT_CNT_EN defined, SHALL add output pkt_cnt[NUM_PORTS], CNT_WIDTH each, incremented once per accepted last beat of that port, wrapping modulo 2^CNT_WIDTH, and cleared by reset.
REQ-027 Without AXIS_ARB_PKT_CNT_EN, the pkt_cnt port and its counters SHALL not exist; all other behaviour is identical.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, LOCKED), AXIS_DATA_WIDTH=512 and AXIS_KEEP_WIDTH=64.
REQ-029 The output register SHALL be sub-module axis_arb_out_reg (skid pipeline stage, same handshake).
REQ-030 Interface-array inputs SHALL be unrolled by a generate loop into flat vectors before muxing; no variable interface index.

Verification
REQ-031 Ports 0 and 2 both present 3-beat packets out of reset -> port 0 packet (3 beats) then port 2 packet, no interleave, one idle cycle between.
REQ-032 All 4 ports continuously valid, single-beat packets -> grant sequence 0,1,2,3,0,1; each beat appears on m_axis 1 cycle after acceptance.
REQ-033 m_axis.ready toggled 1,0,1,0 during an 8-beat packet from port 1 -> all 8 beats out in order, data/keep/user bit-exact.
REQ-034 Port 3 drops valid for 5 cycles mid-packet while port 0 is valid -> grant stays 3 and port 0 ready stays 0 until port 3's last.
REQ-035 areset asserted on beat 2 of a 4-beat packet -> next cycle m_axis.valid=0, busy=0, and port 0 wins the next arbitration.
REQ-036 With AXIS_ARB_PKT_CNT_EN: 5 packets on port 1, 2 on port 2 -> pkt_cnt[1]=5, pkt_cnt[2]=2, others 0; with CNT_WIDTH=2, 5 packets -> pkt_cnt=1.
